mic_fir_scheduler: RTL and testbench

- Time-multiplexes one shared anti-alias FIR filter across the three I2S mic channels.
- The FIR is configured as a 3-channel TDM filter that expects samples in strict order ch0, ch1, ch2.
- The block buffers one sample per mic, issues samples to the FIR in order over an AXI-stream-style handshake, and routes FIR outputs back to their channel.
- It decimates each channel and presents per-channel samples with valid pulses to the downstream audio path.

---
 rtl/mic_fir_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_mic_fir_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mic_fir_scheduler.sv
// mic_fir_scheduler: shares one 3-channel TDM FIR across three mic channels.
// Samples go to the FIR in strict ch0/ch1/ch2 order, and the returned results are decimated per channel.
// Defining SCHED_STATS_EN adds per-channel overrun counters and a FIR stall counter.
module mic_fir_scheduler #(
  parameter int WIDTH        = 16,
  parameter int DECIMATE     = 2,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [2:0]         valid_in,
  input  logic [3*WIDTH-1:0] audio_in,
  output logic               fir_tvalid,
  output logic [WIDTH-1:0]   fir_tdata,
  input  logic               fir_tready,
  input  logic               fir_out_valid,
  input  logic [WIDTH-1:0]   fir_out_data,
  output logic [2:0]         ch_valid_out,
  output logic [3*WIDTH-1:0] ch_data_out,
  output logic [2:0]         overrun_out,
  output logic               error_out
`ifdef SCHED_STATS_EN
  ,
  output logic [3*8-1:0]     overrun_cnt_out,
  output logic [15:0]        stall_cnt_out
`endif
);

  if (DECIMATE < 1 || DECIMATE > 16) begin : g_bad_decimate
    $error("DECIMATE must be in 1..16");
  end
  if (MAX_INFLIGHT < 1 || MAX_INFLIGHT > 15) begin : g_bad_inflight
    $error("MAX_INFLIGHT must be in 1..15");
  end

  localparam logic [3:0] MAX_INF  = 4'(MAX_INFLIGHT);
  localparam logic [3:0] DEC_LAST = 4'(DECIMATE - 1);

  typedef enum logic [1:0] {
    ISSUE0 = 2'd0,
    ISSUE1 = 2'd1,
    ISSUE2 = 2'd2
  } issue_state_e;

  issue_state_e            state_q, state_d;
  logic [2:0][WIDTH-1:0]   buf_q, buf_d;
  logic [2:0]              pend_q, pend_d;
  logic                    fir_tvalid_q, fir_tvalid_d;
  logic [WIDTH-1:0]        fir_tdata_q, fir_tdata_d;
  logic [3:0]              inflight_q, inflight_d;
  logic [1:0]              out_ch_q, out_ch_d;
  logic [2:0][3:0]         dcnt_q, dcnt_d;
  logic [2:0]              ch_valid_q, ch_valid_d;
  logic [2:0][WIDTH-1:0]   ch_data_q, ch_data_d;
  logic [2:0]              overrun_q, overrun_d;
  logic                    error_q, error_d;

  logic [1:0]              cur_ch;
  logic                    load;
  logic                    handshake;
  logic                    result_ok;
  logic                    result_err;
  logic [2:0]              consumed;
  logic [2:0]              overrun_evt;

  always_comb begin
    cur_ch     = 2'(state_q);
    load       = !fir_tvalid_q && pend_q[cur_ch] && (inflight_q < MAX_INF);
    handshake  = fir_tvalid_q && fir_tready;
    result_ok  = fir_out_valid && (inflight_q != 4'd0);
    result_err = fir_out_valid && (inflight_q == 4'd0);
    consumed   = load ? (3'b001 << cur_ch) : 3'b000;
  end

  // A new arrival overwrites the buffer even while its channel is being loaded; the load takes the old value.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      buf_d[i]       = valid_in[i] ? audio_in[i*WIDTH +: WIDTH] : buf_q[i];
      pend_d[i]      = valid_in[i] | (pend_q[i] & ~consumed[i]);
      overrun_evt[i] = valid_in[i] & pend_q[i] & ~consumed[i];
    end
    overrun_d = overrun_q | overrun_evt;
  end

  // NOTE: each always_comb assigns every output a default first, so no path can leave a latch behind.
  always_comb begin
    state_d      = state_q;
    fir_tvalid_d = fir_tvalid_q;
    fir_tdata_d  = fir_tdata_q;
    if (handshake) begin
      fir_tvalid_d = 1'b0;
      unique case (state_q)
        ISSUE0:  state_d = ISSUE1;
        ISSUE1:  state_d = ISSUE2;
        default: state_d = ISSUE0;
      endcase
    end else if (load) begin
      fir_tvalid_d = 1'b1;
      fir_tdata_d  = buf_q[cur_ch];
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    unique case ({handshake, result_ok})
      2'b10:   inflight_d = inflight_q + 4'd1;
      2'b01:   inflight_d = inflight_q - 4'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  // Results return in issue order, so out_ch follows the FIR's TDM rotation.
  always_comb begin
    out_ch_d   = out_ch_q;
    dcnt_d     = dcnt_q;
    ch_valid_d = 3'b000;
    ch_data_d  = ch_data_q;
    error_d    = error_q | result_err;
    if (result_ok) begin
      out_ch_d = (out_ch_q == 2'd2) ? 2'd0 : out_ch_q + 2'd1;
      if (dcnt_q[out_ch_q] == DEC_LAST) begin
        dcnt_d[out_ch_q]     = 4'd0;
        ch_valid_d[out_ch_q] = 1'b1;
        ch_data_d[out_ch_q]  = fir_out_data;
      end else begin
        dcnt_d[out_ch_q] = dcnt_q[out_ch_q] + 4'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ISSUE0;
      pend_q       <= 3'b000;
      fir_tvalid_q <= 1'b0;
      fir_tdata_q  <= '0;
      inflight_q   <= 4'd0;
      out_ch_q     <= 2'd0;
      dcnt_q       <= '0;
      ch_valid_q   <= 3'b000;
      ch_data_q    <= '0;
      overrun_q    <= 3'b000;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      fir_tvalid_q <= fir_tvalid_d;
      fir_tdata_q  <= fir_tdata_d;
      inflight_q   <= inflight_d;
      out_ch_q     <= out_ch_d;
      dcnt_q       <= dcnt_d;
      ch_valid_q   <= ch_valid_d;
      ch_data_q    <= ch_data_d;
      overrun_q    <= overrun_d;
      error_q      <= error_d;
    end
  end

  // NOTE: the sample buffers carry no reset; pend_q gates every read, so their reset contents never matter.
  always_ff @(posedge clk_in) begin
    buf_q <= buf_d;
  end

  assign fir_tvalid   = fir_tvalid_q;
  assign fir_tdata    = fir_tdata_q;
  assign ch_valid_out = ch_valid_q;
  assign ch_data_out  = ch_data_q;
  assign overrun_out  = overrun_q;
  assign error_out    = error_q;

`ifdef SCHED_STATS_EN
  logic [2:0][7:0] overrun_cnt_q, overrun_cnt_d;
  logic [15:0]     stall_cnt_q, stall_cnt_d;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      overrun_cnt_d[i] = (overrun_evt[i] && overrun_cnt_q[i] != 8'hFF)
                         ? overrun_cnt_q[i] + 8'd1 : overrun_cnt_q[i];
    end
    stall_cnt_d = (fir_tvalid_q && !fir_tready && stall_cnt_q != 16'hFFFF)
                  ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      overrun_cnt_q <= '0;
      stall_cnt_q   <= 16'd0;
    end else begin
      overrun_cnt_q <= overrun_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign overrun_cnt_out = overrun_cnt_q;
  assign stall_cnt_out   = stall_cnt_q;
`else
  // The default build has no statistics counters.
`endif

endmodule

// File: tb/tb_mic_fir_scheduler.sv
// Self-checking bench for mic_fir_scheduler: a table of per-cycle vectors, an echoing FIR model with a scoreboard,
// and hand-written corner sequences.
module tb_mic_fir_scheduler;
  localparam int W   = 16;
  localparam int DEC = 2;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic           rst_in = 1'b1;
  logic [2:0]     valid_in = '0;
  logic [3*W-1:0] audio_in = '0;
  logic           fir_tready = 1'b0, fir_out_valid = 1'b0;
  logic [W-1:0]   fir_out_data = '0;
  logic           fir_tvalid, error_out;
  logic [W-1:0]   fir_tdata;
  logic [2:0]     ch_valid_out, overrun_out;
  logic [3*W-1:0] ch_data_out;

  logic [2:0]     l_valid = '0;
  logic [3*W-1:0] l_audio = '0;
  logic           l_rdy = 1'b0, l_fov = 1'b0;
  logic [W-1:0]   l_fod = '0;
  logic           l_tvalid, l_error;
  logic [W-1:0]   l_tdata;
  logic [2:0]     l_chv, l_ovr;
  logic [3*W-1:0] l_chd;
`ifdef SCHED_STATS_EN
  logic [23:0] ovr_cnt, l_ovr_cnt;
  logic [15:0] stall_cnt, l_stall_cnt;
`endif

  mic_fir_scheduler #(.WIDTH(W), .DECIMATE(DEC), .MAX_INFLIGHT(8)) u_dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .audio_in(audio_in),
    .fir_tvalid(fir_tvalid), .fir_tdata(fir_tdata), .fir_tready(fir_tready),
    .fir_out_valid(fir_out_valid), .fir_out_data(fir_out_data),
    .ch_valid_out(ch_valid_out), .ch_data_out(ch_data_out),
    .overrun_out(overrun_out), .error_out(error_out)
`ifdef SCHED_STATS_EN
    , .overrun_cnt_out(ovr_cnt), .stall_cnt_out(stall_cnt)
`endif
  );

  mic_fir_scheduler #(.WIDTH(W), .DECIMATE(1), .MAX_INFLIGHT(2)) u_lim (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(l_valid), .audio_in(l_audio),
    .fir_tvalid(l_tvalid), .fir_tdata(l_tdata), .fir_tready(l_rdy),
    .fir_out_valid(l_fov), .fir_out_data(l_fod),
    .ch_valid_out(l_chv), .ch_data_out(l_chd),
    .overrun_out(l_ovr), .error_out(l_error)
`ifdef SCHED_STATS_EN
    , .overrun_cnt_out(l_ovr_cnt), .stall_cnt_out(l_stall_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk_in) cyc = cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  typedef struct {
    logic rst; logic [2:0] vin; logic [W-1:0] a0, a1, a2;
    logic rdy; logic fov; logic [W-1:0] fod;
    logic e_tv; logic [W-1:0] e_td; logic [2:0] e_ovr; logic e_err; logic [2:0] e_chv;
  } vec_t;
  vec_t vecs[$];

  task automatic row(input logic rst, input logic [2:0] vin, input logic [W-1:0] a0, a1, a2,
                     input logic rdy, input logic fov, input logic [W-1:0] fod,
                     input logic e_tv, input logic [W-1:0] e_td, input logic [2:0] e_ovr,
                     input logic e_err, input logic [2:0] e_chv);
    vecs.push_back('{rst, vin, a0, a1, a2, rdy, fov, fod, e_tv, e_td, e_ovr, e_err, e_chv});
  endtask

  // Echoing FIR model and return-path reference model.
  typedef struct { logic [W-1:0] data; int due; } pipe_t;
  typedef struct { int ch; logic [W-1:0] data; int due; } exp_t;
  pipe_t         pipe[$];
  exp_t          exp_q[$];
  logic [W-1:0]  exp_iss[$];
  logic [W-1:0]  rx0[$];
  int            pulses[3];
  int            m_out_ch;
  int            m_dcnt[3];
  int            l_hs_cnt = 0;
  bit            echo_en = 0, sb_en = 0, iss_en = 0;

  always @(negedge clk_in) begin
    pipe_t p;
    if (echo_en) begin
      fir_out_valid = 1'b0;
      if (fir_tvalid && fir_tready) pipe.push_back('{fir_tdata, cyc + 5});
      if (pipe.size() > 0 && pipe[0].due == cyc) begin
        p = pipe.pop_front();
        fir_out_valid = 1'b1;
        fir_out_data  = p.data;
        if (m_dcnt[m_out_ch] == DEC - 1) exp_q.push_back('{m_out_ch, p.data, cyc + 1});
        m_dcnt[m_out_ch] = (m_dcnt[m_out_ch] + 1) % DEC;
        m_out_ch = (m_out_ch + 1) % 3;
      end
    end
  end

  always @(negedge clk_in) begin
    exp_t e;
    if (sb_en && ch_valid_out != 3'b000) begin
      check("ch pulse expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ch_valid one-hot", 64'(ch_valid_out), 64'(3'b001 << e.ch));
        check("ch_data", 64'(ch_data_out[e.ch*W +: W]), 64'(e.data));
        check("ch latency", 64'(cyc), 64'(e.due));
        pulses[e.ch]++;
        if (e.ch == 0) rx0.push_back(ch_data_out[W-1:0]);
      end
    end
    if (iss_en && fir_tvalid && fir_tready) begin
      check("issue expected", 64'(exp_iss.size() > 0), 64'd1);
      if (exp_iss.size() > 0) check("issue data", 64'(fir_tdata), 64'(exp_iss.pop_front()));
    end
    if (l_tvalid && l_rdy) l_hs_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    step(2);
    check("reset tvalid", 64'(fir_tvalid), 64'd0);
    check("reset tdata", 64'(fir_tdata), 64'd0);
    check("reset ch_valid", 64'(ch_valid_out), 64'd0);
    check("reset ch_data", 64'(ch_data_out), 64'd0);
    check("reset overrun", 64'(overrun_out), 64'd0);
    check("reset error", 64'(error_out), 64'd0);

    // In-order issue, inflight of 3, error on a result with nothing in flight, the error path after reset, and a stalled FIR.
    row(0, 3'b111, 16'h0011, 16'h0022, 16'h0033, 1, 0, 0,        0, 16'h0000, 0, 0, 0);
    row(0, 0, 0, 0, 0, 1, 0, 0,                                  1, 16'h0011, 0, 0, 0);
    row(0, 0, 0, 0, 0, 1, 0, 0,                                  0, 16'h0011, 0, 0, 0);
    row(0, 0, 0, 0, 0, 1, 0, 0,                                  1, 16'h0022, 0, 0, 0);
    row(0, 0, 0, 0, 0, 1, 0, 0,                                  0, 16'h0022, 0, 0, 0);
    row(0, 0, 0, 0, 0, 1, 0, 0,                                  1, 16'h0033, 0, 0, 0);
    row(0, 0, 0, 0, 0, 1, 0, 0,                                  0, 16'h0033, 0, 0, 0);
    row(0, 0, 0, 0, 0, 1, 1, 16'h0100,                           0, 16'h0033, 0, 0, 0);
    row(0, 0, 0, 0, 0, 1, 1, 16'h0200,                           0, 16'h0033, 0, 0, 0);
    row(0, 0, 0, 0, 0, 1, 1, 16'h0300,                           0, 16'h0033, 0, 0, 0);
    row(0, 0, 0, 0, 0, 1, 1, 16'h0400,                           0, 16'h0033, 0, 1, 0);
    row(1, 0, 0, 0, 0, 1, 0, 0,                                  0, 16'h0000, 0, 0, 0);
    row(0, 0, 0, 0, 0, 1, 1, 16'h0500,                           0, 16'h0000, 0, 1, 0);
    row(1, 0, 0, 0, 0, 0, 0, 0,                                  0, 16'h0000, 0, 0, 0);
    row(0, 3'b001, 16'h0AAA, 0, 0, 0, 0, 0,                      0, 16'h0000, 0, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 0,                                  1, 16'h0AAA, 0, 0, 0);
    row(0, 3'b001, 16'h0BBB, 0, 0, 0, 0, 0,                      1, 16'h0AAA, 0, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 0,                                  1, 16'h0AAA, 0, 0, 0);
    row(0, 3'b001, 16'h0CCC, 0, 0, 0, 0, 0,                      1, 16'h0AAA, 3'b001, 0, 0);
    for (int k = 0; k < 6; k++)
      row(0, 0, 0, 0, 0, 0, 0, 0,                                1, 16'h0AAA, 3'b001, 0, 0);
    row(0, 0, 0, 0, 0, 1, 0, 0,                                  0, 16'h0AAA, 3'b001, 0, 0);
    row(0, 0, 0, 0, 0, 1, 0, 0,                                  0, 16'h0AAA, 3'b001, 0, 0);

    rst_in = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      rst_in = vecs[i].rst; valid_in = vecs[i].vin;
      audio_in = {vecs[i].a2, vecs[i].a1, vecs[i].a0};
      fir_tready = vecs[i].rdy; fir_out_valid = vecs[i].fov; fir_out_data = vecs[i].fod;
      step();
      check($sformatf("row%0d tvalid/tdata", i), 64'({fir_tvalid, fir_tdata}), 64'({vecs[i].e_tv, vecs[i].e_td}));
      check($sformatf("row%0d overrun", i), 64'(overrun_out), 64'(vecs[i].e_ovr));
      check($sformatf("row%0d error", i), 64'(error_out), 64'(vecs[i].e_err));
      check($sformatf("row%0d ch_valid", i), 64'(ch_valid_out), 64'(vecs[i].e_chv));
    end
    rst_in = 1'b1; valid_in = '0; fir_out_valid = 1'b0;
    step(2);
    rst_in = 1'b0;

    // Echo FIR with a 5-cycle latency, four rounds on all three channels.
    m_out_ch = 0; m_dcnt = '{0, 0, 0}; pulses = '{0, 0, 0};
    fir_tready = 1'b1; echo_en = 1; sb_en = 1;
    for (int r = 1; r <= 4; r++) begin
      valid_in = 3'b111;
      audio_in = {16'(16'h0020 + r), 16'(16'h0010 + r), 16'(r)};
      step();
      valid_in = '0;
      step(7);
    end
    step(20);
    echo_en = 0;
    fir_out_valid = 1'b0;
    check("echo results drained", 64'(exp_q.size()), 64'd0);
    for (int c = 0; c < 3; c++) check($sformatf("ch%0d pulse count", c), 64'(pulses[c]), 64'd2);
    check("ch0 kept count", 64'(rx0.size()), 64'd2);
    check("ch0 kept first", 64'(rx0[0]), 64'd2);
    check("ch0 kept second", 64'(rx0[1]), 64'd4);

    // Missing ch1 stalls ch2; the newest ch2 sample wins once ch1 arrives.
    iss_en = 1;
    exp_iss.push_back(16'h0100);
    for (int i = 0; i < 4; i++) begin
      valid_in = 3'b101;
      audio_in = {16'(16'h0300 + i), 16'h0000, 16'(16'h0100 + i)};
      step();
      valid_in = '0;
      step(3);
    end
    check("only first ch0 issued", 64'(exp_iss.size()), 64'd0);
    check("ch2 overrun", 64'(overrun_out[2]), 64'd1);
    exp_iss.push_back(16'h0222); exp_iss.push_back(16'h0303); exp_iss.push_back(16'h0103);
    valid_in = 3'b010;
    audio_in = {16'h0000, 16'h0222, 16'h0000};
    step();
    valid_in = '0;
    step(10);
    check("released issues done", 64'(exp_iss.size()), 64'd0);
    iss_en = 0;

    // Reset mid-stream with a loaded FIR word.
    fir_tready = 1'b0;
    valid_in = 3'b111;
    audio_in = {3{16'h0777}};
    step();
    valid_in = '0;
    step(2);
    check("pre-reset tvalid", 64'(fir_tvalid), 64'd1);
    rst_in = 1'b1;
    step();
    check("mid reset tvalid", 64'(fir_tvalid), 64'd0);
    check("mid reset tdata", 64'(fir_tdata), 64'd0);
    check("mid reset overrun", 64'(overrun_out), 64'd0);
    check("mid reset error", 64'(error_out), 64'd0);
    check("mid reset ch_data", 64'(ch_data_out), 64'd0);
    check("mid reset ch_valid", 64'(ch_valid_out), 64'd0);
    rst_in = 1'b0;
    step();

    // MAX_INFLIGHT = 2 with DECIMATE = 1; the FIR returns one result on demand.
    l_hs_cnt = 0;
    l_rdy = 1'b1;
    l_valid = 3'b111;
    l_audio = {16'h000C, 16'h000B, 16'h000A};
    step();
    l_valid = '0;
    step(12);
    check("lim handshakes at cap", 64'(l_hs_cnt), 64'd2);
    check("lim tvalid idle at cap", 64'(l_tvalid), 64'd0);
    l_fov = 1'b1;
    l_fod = 16'h0055;
    step();
    l_fov = 1'b0;
    check("lim pass-through valid", 64'(l_chv), 64'd1);
    check("lim pass-through data", 64'(l_chd[W-1:0]), 64'h0055);
    check("lim no error", 64'(l_error), 64'd0);
    step(6);
    check("lim one more issue", 64'(l_hs_cnt), 64'd3);
    check("lim tvalid idle again", 64'(l_tvalid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
